// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver for an N-digit common-anode display.
// Double-buffered load port, per-digit enables, decimal points and leading-zero blanking.
module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick, wrap, blank, zrun;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              nib;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h18;
      4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h27;  4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;  default: hex2seg = 7'h0E;
    endcase
  endfunction

  assign tick       = (pcnt_q == PCNT_MAX);
  assign wrap       = tick && (idx_q == IDX_MAX);
  assign frame_done = wrap;

  // lead_zero[i]: digit i and every digit above it hold nibble 0
  always_comb begin
    zrun      = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun         = zrun && (act_val_q[4*i +: 4] == 4'h0);
      lead_zero[i] = zrun;
    end
  end

  always_comb begin
    nib   = act_val_q[4*int'(idx_q) +: 4];
    blank = !act_en_q[idx_q] || (lz_blank && (idx_q != '0) && lead_zero[idx_q]);
    sseg_d = blank ? 7'h7F : hex2seg(nib);
    dp_d   = blank ? 1'b1  : ~act_dp_q[idx_q];
    an_d   = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_comb begin
    pcnt_d       = tick ? '0 : pcnt_q + PW'(1);
    idx_d        = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    // A load landing on the wrap bypasses the pending buffer entirely
    if (load && wrap) begin
      act_val_d    = value;
      act_dp_d     = dp_in;
      act_en_d     = digit_en;
      pend_valid_d = 1'b0;
    end else begin
      if (wrap && pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        act_en_d     = pend_en_q;
        pend_valid_d = 1'b0;
      end
      if (load) begin
        pend_val_d   = value;
        pend_dp_d    = dp_in;
        pend_en_d    = digit_en;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign sseg = sseg_q;
  assign dp   = dp_q;
  assign an   = an_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized bench for sseg_scan_driver (4 digits, 4-cycle slots) against a
// frame-level reference model built from edge counts since reset release.
module tb_sseg_scan_driver;
  localparam int ND = 4, RD = 4, FR = ND * RD;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, digit_en = '0;
  logic        lz_blank = 1'b0, load = 1'b0;
  logic [6:0]  sseg;
  logic        dp, frame_done;
  logic [3:0]  an;

  int n_cmp = 0, n_fail = 0;

  sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .sseg(sseg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0]  font [16];
  // model: active/pending buffers, snapshot used by the output register, edge count
  logic [15:0] m_aval, m_pval, s_val;
  logic [3:0]  m_adp, m_pdp, m_aen, m_pen, s_dp, s_en;
  logic        m_pv, s_lz;
  int          e;
  logic [6:0]  x_sseg;
  logic        x_dp, x_fd;
  logic [3:0]  x_an;

  task automatic model_reset();
    m_aval = '0; m_pval = '0; m_adp = '0; m_pdp = '0;
    m_aen = '0; m_pen = '0; m_pv = 1'b0; e = 0;
  endtask

  // One clock: apply the buffering rules for this edge, then form expected pins
  task automatic cyc();
    logic wrap, blank;
    int   d;
    wrap = (e % FR == FR - 1);
    s_val = m_aval; s_dp = m_adp; s_en = m_aen; s_lz = lz_blank;
    if (load && wrap) begin
      m_aval = value; m_adp = dp_in; m_aen = digit_en; m_pv = 1'b0;
    end else begin
      if (wrap && m_pv) begin
        m_aval = m_pval; m_adp = m_pdp; m_aen = m_pen; m_pv = 1'b0;
      end
      if (load) begin
        m_pval = value; m_pdp = dp_in; m_pen = digit_en; m_pv = 1'b1;
      end
    end
    @(posedge clk);
    e++;
    @(negedge clk);
    d      = ((e - 1) / RD) % ND;
    blank  = !s_en[d] || (s_lz && d >= 1 && (s_val >> (4 * d)) == 0);
    x_sseg = blank ? 7'h7F : font[s_val[4*d +: 4]];
    x_dp   = blank ? 1'b1 : ~s_dp[d];
    x_an   = ~(4'b0001 << d);
    x_fd   = (e % FR == FR - 1);
  endtask

  task automatic advance_to(input int phase);
    while (e % FR != phase) cyc();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sseg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got sseg=%h dp=%b an=%h fd=%b exp 7f 1 f 0", sseg, dp, an, frame_done);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FR + 3; i++) begin
      cyc();
      n_cmp++;
      if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
        n_fail++;
        $display("FAIL first_display e=%0d: got %h %b %h %b exp %h %b %h %b",
                 e, sseg, dp, an, frame_done, x_sseg, x_dp, x_an, x_fd);
      end
    end
  endtask

  task automatic test_double_buffer();
    advance_to(6);
    value = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      cyc();
      n_cmp++;
      if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
        n_fail++;
        $display("FAIL double_buffer e=%0d: got %h %b %h %b exp %h %b %h %b",
                 e, sseg, dp, an, frame_done, x_sseg, x_dp, x_an, x_fd);
      end
    end
  endtask

  task automatic test_lz_blank();
    lz_blank = 1'b1;
    foreach (font[k]) if (k < 2) begin
      value = (k == 0) ? 16'h0050 : 16'h0000;
      load  = 1'b1;
      cyc();
      load  = 1'b0;
      for (int i = 0; i < 2 * FR; i++) begin
        cyc();
        n_cmp++;
        if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
          n_fail++;
          $display("FAIL lz_blank v=%h e=%0d: got %h %b %h exp %h %b %h",
                   value, e, sseg, dp, an, x_sseg, x_dp, x_an);
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_dp_enable();
    for (int k = 0; k < 2; k++) begin
      value    = 16'h8A3C;
      dp_in    = (k == 0) ? 4'b0100 : 4'b0010;
      digit_en = (k == 0) ? 4'b1011 : 4'b1111;
      load     = 1'b1;
      cyc();
      load     = 1'b0;
      for (int i = 0; i < 2 * FR; i++) begin
        cyc();
        n_cmp++;
        if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
          n_fail++;
          $display("FAIL dp_enable k=%0d e=%0d: got %h %b %h exp %h %b %h",
                   k, e, sseg, dp, an, x_sseg, x_dp, x_an);
        end
      end
    end
  endtask

  task automatic test_load_at_wrap();
    digit_en = 4'hF; dp_in = 4'h0;
    advance_to(FR - 1);
    value = 16'hBEEF; load = 1'b1;
    cyc();
    value = 16'h1234;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 3 * FR; i++) begin
      cyc();
      n_cmp++;
      if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
        n_fail++;
        $display("FAIL load_at_wrap e=%0d: got %h %b %h %b exp %h %b %h %b",
                 e, sseg, dp, an, frame_done, x_sseg, x_dp, x_an, x_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        load = 1'b1; value = 16'($urandom);
        if ($urandom_range(1) == 0) value = value & 16'h00FF;
        dp_in = 4'($urandom); digit_en = 4'($urandom);
      end else load = 1'b0;
      if ($urandom_range(15) == 0) lz_blank = 1'($urandom);
      cyc();
      n_cmp++;
      if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
        n_fail++;
        $display("FAIL random e=%0d: got %h %b %h %b exp %h %b %h %b",
                 e, sseg, dp, an, frame_done, x_sseg, x_dp, x_an, x_fd);
      end
    end
    load = 1'b0; lz_blank = 1'b0;
  endtask

  task automatic test_mid_reset();
    advance_to(4);
    value = 16'h7777; digit_en = 4'hF; load = 1'b1;
    cyc();
    load = 1'b0;
    advance_to(10);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sseg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h %b %h %b exp 7f 1 f 0", sseg, dp, an, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      cyc();
      n_cmp++;
      if ({sseg, dp, an, frame_done} !== {x_sseg, x_dp, x_an, x_fd}) begin
        n_fail++;
        $display("FAIL after_mid_reset e=%0d: got %h %b %h %b exp %h %b %h %b",
                 e, sseg, dp, an, frame_done, x_sseg, x_dp, x_an, x_fd);
      end
    end
  endtask

  initial begin
    font = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    model_reset();
    test_reset();
    test_double_buffer();
    test_lz_blank();
    test_dp_enable();
    test_load_at_wrap();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
